// File: rtl/mips_pkg.sv
// Shared MIPS subset definitions: opcode/funct constants, instruction formats
// and loader state encoding, common to the loader and the control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MUL   = 6'b011100;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_ILLEGAL
    } instr_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } loader_state_e;

    function automatic logic is_legal_funct(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_SLT, FN_MUL};
    endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational encoder: classifies an opcode/funct pair and packs the
// relevant fields into a 32-bit R/I/J word; illegal pairs yield a zero word.
module mips_instr_encoder
    import mips_pkg::*;
(
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output instr_fmt_e  fmt,
    output logic [31:0] word
);

    always_comb begin
        fmt  = FMT_ILLEGAL;
        word = '0;
        case (in_opcode)
            OP_RTYPE: begin
                if (is_legal_funct(in_funct)) begin
                    fmt  = FMT_R;
                    word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
                end
            end
            OP_LW, OP_SW, OP_ADDI, OP_BEQ: begin
                fmt  = FMT_I;
                word = {in_opcode, in_rs, in_rt, in_imm};
            end
            OP_J: begin
                fmt  = FMT_J;
                word = {in_opcode, in_target};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: accepts decoded fields over valid/ready, encodes
// legal instructions and writes them to sequential word addresses.
module instr_mem_loader #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       finish,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_opcode,
    input  logic [5:0]                 in_funct,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_shamt,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_target,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic                       err
);
    import mips_pkg::*;

    localparam int unsigned        CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              imem_we_q, imem_we_d;
    logic              err_q, err_d;
    logic              xfer;
    instr_fmt_e        enc_fmt;
    logic [31:0]       enc_word;

    mips_instr_encoder u_enc (
        .in_opcode (in_opcode),
        .in_funct  (in_funct),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .fmt       (enc_fmt),
        .word      (enc_word)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_addr_d    = wr_addr_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_we_d    = 1'b0;
        err_d        = err_q;
        in_ready     = (state_q == ST_LOAD) && (count_q < FULL);
        xfer         = in_valid && in_ready;

        // start wins over finish and discards any transfer offered alongside it
        if (start) begin
            state_d     = ST_LOAD;
            count_d     = '0;
            wr_addr_d   = BASE;
            imem_addr_d = BASE;
            err_d       = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (xfer) begin
                if (enc_fmt != FMT_ILLEGAL) begin
                    imem_we_d    = 1'b1;
                    imem_wdata_d = enc_word;
                    imem_addr_d  = wr_addr_q;
                    wr_addr_d    = wr_addr_q + ADDR_W'(4);
                    count_d      = count_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            if (finish || count_d == FULL) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            wr_addr_q    <= BASE;
            imem_addr_q  <= BASE;
            imem_wdata_q <= '0;
            imem_we_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_addr_q    <= wr_addr_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_we_q    <= imem_we_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (DEPTH=4, BASE_ADDR=0).
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, in_valid, in_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        done, err;

    int n_cmp = 0;
    int n_err = 0;

    instr_mem_loader #(.ADDR_W(32), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct   (in_funct),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] cnt);
        chk({tag, ".we"},    32'(imem_we), 32'd1);
        chk({tag, ".addr"},  imem_addr,    addr);
        chk({tag, ".wdata"}, imem_wdata,   data);
        chk({tag, ".count"}, 32'(count),   cnt);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".we"},    32'(imem_we),  32'd0);
        chk({tag, ".addr"},  imem_addr,     32'h0);
        chk({tag, ".wdata"}, imem_wdata,    32'h0);
        chk({tag, ".count"}, 32'(count),    32'd0);
        chk({tag, ".done"},  32'(done),     32'd0);
        chk({tag, ".err"},   32'(err),      32'd0);
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] tgt);
        in_opcode = op;  in_rs    = rs;  in_rt  = rt;  in_rd     = rd;
        in_shamt  = sh;  in_funct = fn;  in_imm = imm; in_target = tgt;
        in_valid  = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_imm = '0; in_target = '0;
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk("idle.ready", 32'(in_ready), 32'd0);

        // 1: single lw; stray rd/shamt/funct/target must not leak into the word
        pulse_start();
        chk("t1.ready", 32'(in_ready), 32'd1);
        drive(6'b100011, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3f, 16'h0004, 26'h3ffffff);
        tick();
        in_valid = 1'b0;
        chk_write("t1.lw", 32'h0, 32'h8C220004, 32'd1);
        tick();
        chk("t1.we_low", 32'(imem_we), 32'd0);

        // 2: back-to-back add then j
        pulse_start();
        chk("t2.count_clr", 32'(count), 32'd0);
        drive(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'hffff, 26'h3ffffff);
        tick();
        chk_write("t2.add", 32'h0, 32'h00221820, 32'd1);
        drive(6'b000010, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h0000010);
        tick();
        in_valid = 1'b0;
        chk_write("t2.j", 32'h4, 32'h08000010, 32'd2);
        tick();
        chk("t2.we_low", 32'(imem_we), 32'd0);
        chk("t2.addr_hold", imem_addr, 32'h4);

        // 3: illegal funct, then sw, then illegal opcode
        pulse_start();
        chk("t3.err_clr0", 32'(err), 32'd0);
        drive(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000001, 16'h0, 26'h0);
        tick();
        chk("t3.ill.we", 32'(imem_we), 32'd0);
        chk("t3.ill.err", 32'(err), 32'd1);
        chk("t3.ill.count", 32'(count), 32'd0);
        drive(6'b101011, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
        tick();
        chk_write("t3.sw", 32'h0, 32'hAC050008, 32'd1);
        chk("t3.sw.err", 32'(err), 32'd1);
        drive(6'b001100, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("t3.ill2.we", 32'(imem_we), 32'd0);
        chk("t3.ill2.count", 32'(count), 32'd1);
        chk("t3.ill2.addr", imem_addr, 32'h0);
        pulse_start();
        chk("t3.err_clr", 32'(err), 32'd0);

        // 4: fill to DEPTH with valid held; the fifth addi is never taken
        drive(6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
        tick();
        chk_write("t4.w0", 32'h0, 32'h20010001, 32'd1);
        chk("t4.ready0", 32'(in_ready), 32'd1);
        drive(6'b001000, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0);
        tick();
        chk_write("t4.w1", 32'h4, 32'h20020002, 32'd2);
        drive(6'b001000, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0);
        tick();
        chk_write("t4.w2", 32'h8, 32'h20030003, 32'd3);
        drive(6'b001000, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
        tick();
        chk_write("t4.w3", 32'hC, 32'h20040004, 32'd4);
        chk("t4.ready_full", 32'(in_ready), 32'd0);
        chk("t4.done", 32'(done), 32'd1);
        drive(6'b001000, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
        tick();
        chk("t4.no5.we", 32'(imem_we), 32'd0);
        chk("t4.no5.count", 32'(count), 32'd4);
        chk("t4.no5.addr", imem_addr, 32'hC);
        chk("t4.no5.wdata", imem_wdata, 32'h20040004);
        tick();
        in_valid = 1'b0;
        chk("t4.hold.we", 32'(imem_we), 32'd0);
        chk("t4.hold.done", 32'(done), 32'd1);

        // 5: finish together with a beq transfer
        pulse_start();
        chk("t5.done_clr", 32'(done), 32'd0);
        drive(6'b000100, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        finish = 1'b1;
        tick();
        in_valid = 1'b0;
        finish = 1'b0;
        chk_write("t5.beq", 32'h0, 32'h1022FFFF, 32'd1);
        chk("t5.done", 32'(done), 32'd1);
        chk("t5.ready", 32'(in_ready), 32'd0);
        tick();
        chk("t5.we_low", 32'(imem_we), 32'd0);
        chk("t5.done_hold", 32'(done), 32'd1);

        // start beats finish in the same cycle
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        chk("prio.done", 32'(done), 32'd0);
        chk("prio.ready", 32'(in_ready), 32'd1);
        chk("prio.count", 32'(count), 32'd0);

        // 6: reset mid-session after two writes, with a third transfer pending
        drive(6'b100011, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
        tick();
        chk_write("t6.w0", 32'h0, 32'h8C220004, 32'd1);
        drive(6'b101011, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
        tick();
        chk_write("t6.w1", 32'h4, 32'hAC050008, 32'd2);
        drive(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0);
        rst_n = 1'b0;
        tick();
        chk_reset("t6.rst");
        rst_n = 1'b1;
        tick();
        chk("t6.idle.we", 32'(imem_we), 32'd0);
        chk("t6.idle.count", 32'(count), 32'd0);
        pulse_start();
        chk("t6.start.we", 32'(imem_we), 32'd0);
        tick();
        in_valid = 1'b0;
        chk_write("t6.restart", 32'h0, 32'h00221820, 32'd1);
        tick();
        chk("t6.we_low", 32'(imem_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
